// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared state type and SHA3-256 sponge constants
package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PACK,
    ST_FLUSH,
    ST_PAD,
    ST_PERM,
    ST_DONE
  } hash_seq_state_t;

  localparam int RATE_BYTES = 136;
  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_sponge_seq_if.sv
// rtl/hash_sponge_seq_if.sv - trit intake, byte/pad strobes and permutation handshake
interface hash_sponge_seq_if #(
  parameter int TRITS_PER_BYTE = 5,
  parameter int RATE_BYTES     = hash_pkg::RATE_BYTES,
  parameter int NUM_BLOCKS     = 3
);
  localparam int TW = hash_pkg::cw(TRITS_PER_BYTE);
  localparam int BW = hash_pkg::cw(RATE_BYTES);
  localparam int KW = $clog2(NUM_BLOCKS) + 1;

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] trit_idx;
  logic          byte_load;
  logic [BW-1:0] byte_idx;
  logic [KW-1:0] blk_idx;
  logic          pad_en;
  logic [BW-1:0] pad_idx;
  logic          perm_start;
  logic          perm_done;
  logic          busy;
  logic          done;
  logic          halt_n;

  modport master (
    output start, in_valid, perm_done,
    input  in_ready, trit_idx, byte_load, byte_idx, blk_idx, pad_en, pad_idx,
           perm_start, busy, done, halt_n
  );

  modport slave (
    input  start, in_valid, perm_done,
    output in_ready, trit_idx, byte_load, byte_idx, blk_idx, pad_en, pad_idx,
           perm_start, busy, done, halt_n
  );

endinterface

// File: rtl/hash_wrap_cnt.sv
// rtl/hash_wrap_cnt.sv - modulo (MAX+1) counter with clear, enable and wrap flag
module hash_wrap_cnt #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_max;

  assign at_max = (cnt_q == MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & at_max;

endmodule

// File: rtl/hash_sponge_seq.sv
// rtl/hash_sponge_seq.sv - packs trits into bytes, sequences absorb blocks, padding and Keccak-f calls
module hash_sponge_seq #(
  parameter int TRITS_PER_BYTE = 5,
  parameter int RATE_BYTES     = hash_pkg::RATE_BYTES,
  parameter int NUM_BLOCKS     = 3,
  parameter int LAST_BYTES     = 5
) (
  input logic              ex_clk,
  input logic              ovr_rst_n,
  hash_sponge_seq_if.slave bus
);
  import hash_pkg::*;

  localparam int TW = cw(TRITS_PER_BYTE);
  localparam int BW = cw(RATE_BYTES);
  localparam int KW = $clog2(NUM_BLOCKS) + 1;
  localparam logic [BW-1:0] LAST_IDX     = BW'(LAST_BYTES - 1);
  localparam logic [BW-1:0] PAD_POS      = BW'(LAST_BYTES);
  localparam logic [KW-1:0] LAST_BLK     = KW'(NUM_BLOCKS - 1);
  localparam bit            NO_LAST_DATA = (LAST_BYTES == 0);

  if (LAST_BYTES < 0 || LAST_BYTES >= RATE_BYTES || NUM_BLOCKS < 1 || TRITS_PER_BYTE < 1)
  begin : g_bad_params
    $error("hash_sponge_seq: illegal TRITS_PER_BYTE/RATE_BYTES/NUM_BLOCKS/LAST_BYTES");
  end

  hash_seq_state_t state_q, state_d;
  logic [KW-1:0]   blk_q, blk_d;
  logic [TW-1:0]   trit_cnt;
  logic            trit_wrap;
  logic [BW-1:0]   byte_cnt;
  logic            byte_wrap;
  logic            byte_load_q;
  logic [BW-1:0]   byte_idx_q;
  logic            perm_start_q;
  logic            done_q;
  logic            msg_start, trit_acc, byte_acc, blk_adv, last_blk, limit_hit;

  assign msg_start = bus.start & (state_q == ST_IDLE || state_q == ST_DONE);
  assign trit_acc  = bus.in_valid & (state_q == ST_PACK);
  assign byte_acc  = trit_acc & trit_wrap;
  assign blk_adv   = bus.perm_done & (state_q == ST_PERM);
  assign last_blk  = (blk_q == LAST_BLK);
  // Full blocks end exactly where the byte counter wraps; the short last block ends early.
  assign limit_hit = last_blk ? (byte_acc & (byte_cnt == LAST_IDX)) : byte_wrap;

  hash_wrap_cnt #(.MAX(TRITS_PER_BYTE - 1), .W(TW)) u_trit_cnt (
    .clk_i  (ex_clk),
    .rst_ni (ovr_rst_n),
    .clr_i  (msg_start),
    .en_i   (trit_acc),
    .cnt_o  (trit_cnt),
    .wrap_o (trit_wrap)
  );

  hash_wrap_cnt #(.MAX(RATE_BYTES - 1), .W(BW)) u_byte_cnt (
    .clk_i  (ex_clk),
    .rst_ni (ovr_rst_n),
    .clr_i  (msg_start | blk_adv),
    .en_i   (byte_acc),
    .cnt_o  (byte_cnt),
    .wrap_o (byte_wrap)
  );

  always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          blk_d   = '0;
          state_d = (NUM_BLOCKS == 1 && NO_LAST_DATA) ? ST_PAD : ST_PACK;
        end
      end
      ST_PACK: begin
        if (limit_hit) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = last_blk ? ST_PAD : ST_PERM;
      ST_PAD:   state_d = ST_PERM;
      ST_PERM: begin
        if (bus.perm_done) begin
          blk_d = blk_q + 1'b1;
          if (last_blk) begin
            state_d = ST_DONE;
          end else if (NO_LAST_DATA && ((blk_q + 1'b1) == LAST_BLK)) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_PACK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered strobes: byte_load trails the accepting edge by one cycle.
  always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      byte_load_q  <= 1'b0;
      byte_idx_q   <= '0;
      perm_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      byte_load_q  <= byte_acc;
      if (byte_acc) byte_idx_q <= byte_cnt;
      perm_start_q <= (state_d == ST_PERM) && (state_q != ST_PERM);
      done_q       <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  always_comb begin
    bus.in_ready   = (state_q == ST_PACK);
    bus.busy       = !(state_q == ST_IDLE || state_q == ST_DONE);
    bus.halt_n     = (state_q != ST_DONE);
    bus.pad_en     = (state_q == ST_PAD);
    bus.pad_idx    = (state_q == ST_PAD) ? PAD_POS : '0;
    bus.trit_idx   = trit_cnt;
    bus.byte_load  = byte_load_q;
    bus.byte_idx   = byte_idx_q;
    bus.blk_idx    = blk_q;
    bus.perm_start = perm_start_q;
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_hash_sponge_seq.sv
// tb/tb_hash_sponge_seq.sv - scoreboard bench for hash_sponge_seq over three parameter sets
module tb_hash_sponge_seq;

  localparam int K_BYTE   = 1;
  localparam int K_PAD    = 2;
  localparam int K_PSTART = 3;
  localparam int K_DONE   = 4;
  localparam int K_PROBE  = 5;

  typedef struct packed {
    logic [1:0]  inst;
    logic [2:0]  kind;
    logic [7:0]  blk;
    logic [15:0] idx;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: 8-byte rate, 2 blocks, 3 bytes in last; B: single empty last block; C: defaults
  hash_sponge_seq_if #(.TRITS_PER_BYTE(5), .RATE_BYTES(8), .NUM_BLOCKS(2)) ifa ();
  hash_sponge_seq_if #(.TRITS_PER_BYTE(5), .RATE_BYTES(8), .NUM_BLOCKS(1)) ifb ();
  hash_sponge_seq_if #(.TRITS_PER_BYTE(5), .RATE_BYTES(136), .NUM_BLOCKS(3)) ifc ();

  hash_sponge_seq #(.TRITS_PER_BYTE(5), .RATE_BYTES(8), .NUM_BLOCKS(2), .LAST_BYTES(3))
    dut_a (.ex_clk(clk), .ovr_rst_n(rst_n), .bus(ifa.slave));
  hash_sponge_seq #(.TRITS_PER_BYTE(5), .RATE_BYTES(8), .NUM_BLOCKS(1), .LAST_BYTES(0))
    dut_b (.ex_clk(clk), .ovr_rst_n(rst_n), .bus(ifb.slave));
  hash_sponge_seq dut_c (.ex_clk(clk), .ovr_rst_n(rst_n), .bus(ifc.slave));

  function automatic ev_t mk(input int inst, input int kind, input int blk, input int idx,
                             input int c);
    ev_t e;
    e.inst = inst[1:0];
    e.kind = kind[2:0];
    e.blk  = blk[7:0];
    e.idx  = idx[15:0];
    e.cyc  = c;
    return e;
  endfunction

  task automatic push(input int inst, input int kind, input int blk, input int idx, input int c);
    exp_q.push_back(mk(inst, kind, blk, idx, c));
  endtask

  task automatic check(input ev_t got);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected inst%0d: got kind=%0d blk=%0d idx=%0d cyc=%0d, required no event",
               got.inst, got.kind, got.blk, got.idx, got.cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != got.inst || e.kind != got.kind || e.blk != got.blk || e.idx != got.idx ||
          (e.cyc != -1 && e.cyc != got.cyc)) begin
        miscompares++;
        $display("FAIL event inst%0d: got kind=%0d blk=%0d idx=%0d cyc=%0d, required inst%0d kind=%0d blk=%0d idx=%0d cyc=%0d",
                 got.inst, got.kind, got.blk, got.idx, got.cyc,
                 e.inst, e.kind, e.blk, e.idx, $signed(e.cyc));
      end
    end
  endtask

  task automatic observe(input int inst, input logic bl, input int bidx, input logic pe,
                         input int pidx, input logic ps, input logic dn, input int blk,
                         input logic [2:0] lv);
    if (exp_q.size() != 0 && exp_q[0].kind == 3'(K_PROBE) && exp_q[0].inst == 2'(inst) &&
        exp_q[0].cyc == cyc)
      check(mk(inst, K_PROBE, blk, int'(lv), cyc));
    if (bl) check(mk(inst, K_BYTE, blk, bidx, cyc));
    if (pe) check(mk(inst, K_PAD, blk, pidx, cyc));
    if (ps) check(mk(inst, K_PSTART, blk, 0, cyc));
    if (dn) check(mk(inst, K_DONE, blk, 0, cyc));
  endtask

  // Probe level word is {in_ready, busy, halt_n}.
  always @(negedge clk) begin
    observe(0, ifa.byte_load, int'(ifa.byte_idx), ifa.pad_en, int'(ifa.pad_idx), ifa.perm_start,
            ifa.done, int'(ifa.blk_idx), {ifa.in_ready, ifa.busy, ifa.halt_n});
    observe(1, ifb.byte_load, int'(ifb.byte_idx), ifb.pad_en, int'(ifb.pad_idx), ifb.perm_start,
            ifb.done, int'(ifb.blk_idx), {ifb.in_ready, ifb.busy, ifb.halt_n});
    observe(2, ifc.byte_load, int'(ifc.byte_idx), ifc.pad_en, int'(ifc.pad_idx), ifc.perm_start,
            ifc.done, int'(ifc.blk_idx), {ifc.in_ready, ifc.busy, ifc.halt_n});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Message on A with continuous in_valid; timings relative to the start cycle s.
  task automatic run_a(input bit inject, input bit abort);
    int s;
    s = cyc;
    push(0, K_PROBE, 0, 3'b111, s + 1);
    for (int b = 0; b < 8; b++) begin
      if (b == 7) push(0, K_PROBE, 0, 3'b011, s + 41);
      push(0, K_BYTE, 0, b, s + 6 + 5 * b);
    end
    push(0, K_PSTART, 0, 0, s + 42);
    push(0, K_PROBE, 1, 3'b111, s + 47);
    for (int b = 0; b < 3; b++) push(0, K_BYTE, 1, b, s + 52 + 5 * b);
    push(0, K_PAD, 1, 3, s + 63);
    push(0, K_PSTART, 1, 0, s + 64);
    if (abort) begin
      push(0, K_PROBE, 0, 3'b001, s + 66);
      push(0, K_PROBE, 0, 3'b001, s + 67);
    end else begin
      push(0, K_PROBE, 2, 3'b000, s + 69);
      push(0, K_DONE, 2, 0, s + 69);
      push(0, K_PROBE, 2, 3'b000, s + 70);
    end
    for (int t = 0; t <= (abort ? 67 : 70); t++) begin
      ifa.start     = (t == 0) || (inject && (t == 10 || t == 44));
      ifa.in_valid  = 1'b1;
      ifa.perm_done = (t == 46) || (!abort && t == 68) || (inject && t == 20);
      if (abort && t == 66) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    ifa.start = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.perm_done = 1'b0;
  endtask

  // Random in_valid gaps on A, perm_done held high (same-cycle completion).
  task automatic run_rand();
    int  acc;
    bit  got_done;
    acc = 0;
    got_done = 1'b0;
    for (int b = 0; b < 8; b++) push(0, K_BYTE, 0, b, -1);
    push(0, K_PSTART, 0, 0, -1);
    for (int b = 0; b < 3; b++) push(0, K_BYTE, 1, b, -1);
    push(0, K_PAD, 1, 3, -1);
    push(0, K_PSTART, 1, 0, -1);
    push(0, K_DONE, 2, 0, -1);
    for (int t = 0; t < 3000 && !got_done; t++) begin
      ifa.start     = (t == 0);
      ifa.in_valid  = 1'($urandom_range(0, 1));
      ifa.perm_done = 1'b1;
      if (ifa.in_valid && ifa.in_ready) acc++;
      tick();
      if (ifa.done) got_done = 1'b1;
    end
    ifa.start = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.perm_done = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL rand_done: got no done within 3000 cycles, required done");
    end
    vectors++;
    if (acc != 55) begin
      miscompares++;
      $display("FAIL rand_accepts: got %0d trits accepted, required 55", acc);
    end
    tick();
    tick();
  endtask

  initial begin
    int s;
    ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.perm_done = 1'b0;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.perm_done = 1'b0;
    ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.perm_done = 1'b0;
    rst_n = 1'b0;
    tick();
    push(0, K_PROBE, 0, 3'b001, cyc);
    push(1, K_PROBE, 0, 3'b001, cyc);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Default parameters: one byte after five back-to-back trits
    s = cyc;
    push(2, K_PROBE, 0, 3'b111, s + 1);
    push(2, K_BYTE, 0, 0, s + 6);
    for (int t = 0; t <= 12; t++) begin
      ifc.start = (t == 0);
      ifc.in_valid = (t >= 1 && t <= 5);
      tick();
    end
    ifc.in_valid = 1'b0;

    // Single block with no data bytes goes straight to padding
    s = cyc;
    push(1, K_PROBE, 0, 3'b011, s + 1);
    push(1, K_PAD, 0, 0, s + 1);
    push(1, K_PSTART, 0, 0, s + 2);
    push(1, K_PROBE, 1, 3'b000, s + 5);
    push(1, K_DONE, 1, 0, s + 5);
    for (int t = 0; t <= 6; t++) begin
      ifb.start = (t == 0);
      ifb.in_valid = 1'b1;
      ifb.perm_done = (t == 4);
      tick();
    end
    ifb.in_valid = 1'b0;
    ifb.perm_done = 1'b0;

    run_a(1'b0, 1'b0);
    run_a(1'b1, 1'b0);
    run_rand();
    run_a(1'b0, 1'b1);
    tick();
    run_a(1'b0, 1'b0);
    for (int t = 0; t < 5; t++) tick();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d expected events never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hash_sponge_seq.md
HASH_SPONGE_SEQ -- requirements
Module: hash_sponge_seq

Interface
REQ-001 SHALL have parameter TRITS_PER_BYTE, default 5, meaning trits packed per output byte.
REQ-002 SHALL have parameter RATE_BYTES, default 136, meaning sponge rate in bytes for SHA3-256.
REQ-003 SHALL have parameter NUM_BLOCKS, default 3, meaning absorb blocks per message, including the last one.
REQ-004 SHALL have parameter LAST_BYTES, default 5, meaning data bytes in the last block; legal range 0..RATE_BYTES-1.
REQ-005 SHALL have port ex_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port ovr_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin a message; honoured only in IDLE or DONE.
REQ-008 SHALL have port in_valid, input, 1 bit: a trit is presented.
REQ-009 SHALL have port in_ready, output, 1 bit: high exactly when state is PACK.
REQ-010 SHALL have port trit_idx, output, $clog2(TRITS_PER_BYTE) bits: position of the next trit within the current byte.
REQ-011 SHALL have port byte_load, output, 1 bit: one-cycle pulse meaning a byte is complete.
REQ-012 SHALL have port byte_idx, output, $clog2(RATE_BYTES) bits: block-relative index of the byte being loaded.
REQ-013 SHALL have port blk_idx, output, $clog2(NUM_BLOCKS)+1 bits: index of the current block.
REQ-014 SHALL have port pad_en, output, 1 bit: one-cycle pulse that inserts 0x06 at pad_idx and ORs 0x80 at RATE_BYTES-1.
REQ-015 SHALL have port pad_idx, output, $clog2(RATE_BYTES) bits: equals LAST_BYTES while pad_en is high.
REQ-016 SHALL have port perm_start, output, 1 bit: one-cycle Keccak-f start pulse.
REQ-017 SHALL have port perm_done, input, 1 bit: permutation finished; ignored outside PERM.
REQ-018 SHALL have port busy, output, 1 bit: high in any state other than IDLE and DONE.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-020 SHALL have port halt_n, output, 1 bit: low in DONE, high otherwise.

Function
REQ-021 SHALL implement the states IDLE, PACK, FLUSH, PAD, PERM and DONE.
REQ-022 SHALL transition IDLE/DONE to PACK on start, clearing trit_idx, byte count and blk_idx.
REQ-023 SHALL, in PACK, accept a trit on in_valid & in_ready; trit_idx increments and wraps from TRITS_PER_BYTE-1 to 0.
REQ-024 SHALL, when the trit at TRITS_PER_BYTE-1 is accepted in cycle N, pulse byte_load in cycle N+1 with byte_idx equal to the completed byte's index, then increment the byte count.
REQ-025 SHALL set the block byte limit to RATE_BYTES for blk_idx < NUM_BLOCKS-1 and to LAST_BYTES for the last block.
REQ-026 SHALL move PACK to FLUSH at the edge that accepts the final trit of the limit byte; FLUSH lasts one cycle, in_ready=0, and covers that byte's byte_load.
REQ-027 SHALL move FLUSH to PERM for a non-last block, or FLUSH to PAD for the last block.
REQ-028 SHALL, when LAST_BYTES=0, move PACK directly to PAD on entering the last block.
REQ-029 SHALL hold PAD for one cycle with pad_en=1 and then move to PERM.
REQ-030 SHALL pulse perm_start in the first PERM cycle only and hold in PERM until perm_done.
REQ-031 SHALL, on perm_done, increment blk_idx and clear the byte count; go to PACK if more blocks remain, else to DONE.
REQ-032 SHALL treat perm_done in the same cycle as perm_start as valid completion.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL ignore in_valid outside PACK.
REQ-035 SHALL allow start in DONE to restart immediately, with halt_n returning high the next cycle.
REQ-036 SHALL reject parameters that violate LAST_BYTES < RATE_BYTES, NUM_BLOCKS >= 1 or TRITS_PER_BYTE >= 1 with an elaboration-time error.

Reset
REQ-037 SHALL, on ovr_rst_n low at any time including mid-message, go to IDLE and clear all counters.
REQ-038 SHALL, during reset, drive in_ready, byte_load, pad_en, perm_start, busy and done to 0 and halt_n to 1.
REQ-039 SHALL deassert reset synchronously to ex_clk through an external synchroniser; this block adds none.

Structure
REQ-040 SHALL take the state enum hash_seq_state_t and the SHA3-256 constants RATE_BYTES=136, PAD_FIRST=8'h06 and PAD_LAST=8'h80 from shared package hash_pkg.
REQ-041 SHALL instantiate sub-module hash_wrap_cnt (parametrised MAX, clear, enable, wrap flag) twice: once for trits, once for bytes.

Verification
REQ-042 SHALL check, with defaults, start then 5 trits back-to-back: byte_load pulses once, one cycle after the 5th trit, with byte_idx=0.
REQ-043 SHALL check, with RATE_BYTES=8, NUM_BLOCKS=2, LAST_BYTES=3 and continuous in_valid: 8 byte_loads, FLUSH, perm_start; perm_done after 4 cycles gives blk_idx=1; 3 byte_loads; pad_en with pad_idx=3; perm_start; perm_done gives done=1 and halt_n=0.
REQ-044 SHALL check, with LAST_BYTES=0 and NUM_BLOCKS=1: start gives pad_en the next cycle, then perm_start the cycle after, with no byte_load.
REQ-045 SHALL check start pulses during PACK and PERM and a perm_done pulse during PACK: no state, counter or output change.
REQ-046 SHALL check ovr_rst_n low mid-PERM in block 1: IDLE, blk_idx=0, halt_n=1; the next start runs a full message correctly.
REQ-047 SHALL check randomised in_valid gaps: trit accept count = NUM_BLOCKS-1 * RATE_BYTES*5 + LAST_BYTES*5 exactly.
